cim_bus_arbiter: RTL and testbench
==================================

Name: cim_bus_arbiter

Overview:
- Arbitrates the shared inter-CIM broadcast bus (bus_op, bus_data, bus_target_or_sender) between the master (requester 0) and the NUM_CIMS CIMs (requesters 1..NUM_CIMS).
- Grants ownership to one requester at a time and registers the owner's op, data and sender ID onto the bus.
- Inserts one NOP turnaround cycle between owners.
- Sits in top between master/CIM bus drivers and the bus wires.

Parameters:
- NUM_CIMS, 64, number of CIM requesters; requester count NUM_REQ = NUM_CIMS+1.
- BUS_OP_WIDTH, 4, bus opcode width; opcode 0 is NOP.
- N_STORAGE, 16, width of one bus data word; bus carries 3 words.
- MAX_HOLD, 32, maximum beats per grant (used only by the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req  in  NUM_REQ  per-requester bus request; bit 0 = master
- req_valid  in  NUM_REQ  per-requester beat valid; honoured only for the current owner
- req_op  in  NUM_REQ*BUS_OP_WIDTH  per-requester opcode, packed, requester i at [i*BUS_OP_WIDTH +: BUS_OP_WIDTH]
- req_data  in  NUM_REQ*3*N_STORAGE  per-requester data, packed the same way, signed
- req_target  in  NUM_REQ*$clog2(NUM_CIMS)  per-requester target CIM ID
- grant  out  NUM_REQ  one-hot (or zero) registered ownership
- bus_op  out  BUS_OP_WIDTH  registered bus opcode
- bus_data  out  3*N_STORAGE  registered bus data, signed
- bus_target_or_sender  out  $clog2(NUM_CIMS)  registered target (master owner) or sender ID (CIM owner: requester index-1)
- bus_busy  out  1  high while any grant is active
- timeout_pulse  out  1  one-cycle flag on forced release (tied 0 without the optional feature)

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0; state IDLE; round-robin pointer = 1. Reset mid-grant aborts the grant with no turnaround; the bus is NOP on the next cycle.
- States:
  - IDLE: no grant. If any req bit is set, select the winner and go to OWN; grant is registered, so it is visible one cycle after req is sampled.
  - Winner selection: req[0] (master) has strict priority. Otherwise the first set bit at or after the round-robin pointer among 1..NUM_CIMS, wrapping NUM_CIMS->1.
  - OWN: each cycle with req_valid[owner]=1, the owner's op/data/target are registered onto the bus; the outputs appear the cycle after they are sampled.
  - OWN, req_valid[owner]=0 (req still high): bus_op=0, and bus_data and bus_target_or_sender hold their last values.
  - OWN -> TURN: when req[owner] falls. The beat sampled in that same cycle is ignored. Grant clears on the transition.
  - TURN: exactly one cycle with bus_op=0 and grant=0. The pointer is set to owner+1, wrapping NUM_CIMS->1; the master owning does not move the pointer. Then go to IDLE, or arbitrate directly in TURN so the next grant is visible the cycle after TURN.
- Latency from IDLE: req at t -> grant at t+1 -> owner presents a beat at t+1 -> bus_op valid at t+2.
- bus_target_or_sender: req_target when the owner is the master; owner index-1 when the owner is a CIM. Truncation to $clog2(NUM_CIMS) is exact.
- Simultaneous events:
  - Master and CIM requests in the same cycle: master wins.
  - Owner releases while others request: TURN always precedes the next grant.
  - req_valid from non-owners: ignored.
- Never more than one grant bit set (assertion, simulation only).
- bus_busy = |grant.

Optional Feature:
- Macro: CIM_BUS_ARB_TIMEOUT_EN.
- Defined: beat counter counts valid beats in OWN. When it reaches MAX_HOLD, the arbiter forces OWN->TURN regardless of req, and pulses timeout_pulse for 1 cycle in the TURN cycle. The preempted owner must re-arbitrate; it remains eligible but the pointer has moved past it.
- Undefined: no counter; grants are unbounded; timeout_pulse is tied 0.

Test Plan:
- Reset mid-grant: CIM 3 owns, rst_n=0 one cycle -> next cycle grant=0, bus_op=0, pointer=1.
- Single CIM: req[5]=1 at t, req_valid[5]=1 with op=3, target=9 -> grant[5]=1 at t+1; bus_op=3 and bus_target_or_sender=4 at t+2.
- Contention: req[0], req[2] and req[7] all set -> master granted first. After the master releases and TURN (bus_op=0 for 1 cycle), CIM 2 is granted, then CIM 7.
- Round-robin fairness: CIM 2 and CIM 4 request continuously with releases every 2 beats -> grants alternate 2,4,2,4. Wrap check: pointer 64 with req[1] -> CIM 1 granted.
- Idle beats: owner holds req with req_valid toggling 1,0,1 -> bus_op pattern op,0,op; bus_data holds during the 0 beat.
- Timeout with CIM_BUS_ARB_TIMEOUT_EN, MAX_HOLD=4: CIM 1 streams valid beats -> exactly 4 beats on the bus, then timeout_pulse=1 with bus_op=0, then re-grant to the next requester.

Source files
------------

// File: rtl/cim_bus_arbiter.sv
// Shared inter-CIM broadcast bus arbiter: master strict priority, round-robin among CIMs, NOP turnaround between owners.
// Latency: grant 1 cycle after req; owner beat reaches bus_op 1 cycle after sampling.
// Backpressure: none; owner idles with req_valid=0. CIM_BUS_ARB_TIMEOUT_EN bounds each grant to MAX_HOLD beats.
module cim_bus_arbiter #(
    parameter int NUM_CIMS     = 64,
    parameter int BUS_OP_WIDTH = 4,
    parameter int N_STORAGE    = 16,
    parameter int MAX_HOLD     = 32
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [NUM_CIMS:0]                              req,
    input  logic [NUM_CIMS:0]                              req_valid,
    input  logic [(NUM_CIMS+1)*BUS_OP_WIDTH-1:0]           req_op,
    input  logic signed [(NUM_CIMS+1)*3*N_STORAGE-1:0]     req_data,
    input  logic [(NUM_CIMS+1)*$clog2(NUM_CIMS)-1:0]       req_target,
    output logic [NUM_CIMS:0]                              grant,
    output logic [BUS_OP_WIDTH-1:0]                        bus_op,
    output logic signed [3*N_STORAGE-1:0]                  bus_data,
    output logic [$clog2(NUM_CIMS)-1:0]                    bus_target_or_sender,
    output logic                                           bus_busy,
    output logic                                           timeout_pulse
);
    localparam int NUM_REQ = NUM_CIMS + 1;
    localparam int RW      = $clog2(NUM_REQ);
    localparam int TW      = $clog2(NUM_CIMS);
    localparam int DW      = 3 * N_STORAGE;

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;

    state_t                 r_state, w_next;
    logic [NUM_REQ-1:0]     r_grant;
    logic [RW-1:0]          r_owner, r_ptr;
    logic [BUS_OP_WIDTH-1:0] r_bus_op;
    logic [DW-1:0]          r_bus_data;
    logic [TW-1:0]          r_bus_tos;

    logic                   w_own_req, w_own_vld;
    logic [BUS_OP_WIDTH-1:0] w_own_op;
    logic [DW-1:0]          w_own_dat;
    logic [TW-1:0]          w_own_tgt;
    logic                   w_win_vld, w_grab, w_release, w_hold_exp;
    logic [RW-1:0]          w_win;
    logic [RW:0]            w_idx;

    // Current owner's request lines.
    always_comb begin
        w_own_req = 1'b0;
        w_own_vld = 1'b0;
        w_own_op  = '0;
        w_own_dat = '0;
        w_own_tgt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == RW'(i)) begin
                w_own_req = req[i];
                w_own_vld = req_valid[i];
                w_own_op  = req_op[i*BUS_OP_WIDTH +: BUS_OP_WIDTH];
                w_own_dat = req_data[i*DW +: DW];
                w_own_tgt = req_target[i*TW +: TW];
            end
        end
    end

    // Master first, else first CIM at/after r_ptr, wrapping NUM_CIMS->1.
    always_comb begin
        w_win_vld = 1'b0;
        w_win     = '0;
        w_idx     = '0;
        if (req[0]) begin
            w_win_vld = 1'b1;
        end else begin
            for (int k = 0; k < NUM_CIMS; k++) begin
                w_idx = {1'b0, r_ptr} + (RW+1)'(k);
                if (w_idx > (RW+1)'(NUM_CIMS))
                    w_idx = w_idx - (RW+1)'(NUM_CIMS);
                if (!w_win_vld && req[w_idx[RW-1:0]]) begin
                    w_win_vld = 1'b1;
                    w_win     = w_idx[RW-1:0];
                end
            end
        end
    end

`ifdef CIM_BUS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    assign w_hold_exp = (r_cnt == CW'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_release && w_hold_exp;
            if (w_grab)
                r_cnt <= '0;
            else if (r_state == S_OWN && !w_release && w_own_vld)
                r_cnt <= r_cnt + CW'(1);
        end
    end
    assign timeout_pulse = r_timeout;
`else
    assign w_hold_exp    = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        w_grab    = 1'b0;
        w_release = 1'b0;
        case (r_state)
            S_IDLE, S_TURN: begin
                w_next = S_IDLE;
                if (w_win_vld) begin
                    w_grab = 1'b1;
                    w_next = S_OWN;
                end
            end
            S_OWN: begin
                if (!w_own_req || w_hold_exp) begin
                    w_release = 1'b1;
                    w_next    = S_TURN;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Bus defaults to NOP every cycle; only a valid owner beat overrides it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant    <= '0;
            r_owner    <= '0;
            r_ptr      <= RW'(1);
            r_bus_op   <= '0;
            r_bus_data <= '0;
            r_bus_tos  <= '0;
        end else begin
            r_bus_op <= '0;
            if (w_grab) begin
                r_grant <= NUM_REQ'(1) << w_win;
                r_owner <= w_win;
            end else if (w_release) begin
                r_grant <= '0;
                if (r_owner != '0)
                    r_ptr <= (r_owner == RW'(NUM_CIMS)) ? RW'(1) : r_owner + RW'(1);
            end else if (r_state == S_OWN && w_own_vld) begin
                r_bus_op   <= w_own_op;
                r_bus_data <= w_own_dat;
                r_bus_tos  <= (r_owner == '0) ? w_own_tgt : TW'(r_owner - RW'(1));
            end
        end
    end

    assign grant                = r_grant;
    assign bus_op               = r_bus_op;
    assign bus_data             = r_bus_data;
    assign bus_target_or_sender = r_bus_tos;
    assign bus_busy             = |r_grant;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) assert ($onehot0(r_grant));
    end
`endif
endmodule

// File: tb/tb_cim_bus_arbiter.sv
// Directed bench for cim_bus_arbiter: reset, single owner, idle beats, contention, round-robin, wrap, timeout.
module tb_cim_bus_arbiter;
`ifdef CIM_BUS_ARB_TIMEOUT_EN
    localparam int MH = 4;
`else
    localparam int MH = 32;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [64:0]    req, req_valid;
    logic [259:0]   req_op;
    logic [3119:0]  req_data;
    logic [389:0]   req_target;
    logic [64:0]    grant;
    logic [3:0]     bus_op;
    logic [47:0]    bus_data;
    logic [5:0]     bus_target_or_sender;
    logic           bus_busy, timeout_pulse;

    int n_pass   = 0;
    int n_checks = 0;

    cim_bus_arbiter #(.NUM_CIMS(64), .BUS_OP_WIDTH(4), .N_STORAGE(16), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_valid(req_valid), .req_op(req_op),
        .req_data(req_data), .req_target(req_target), .grant(grant), .bus_op(bus_op),
        .bus_data(bus_data), .bus_target_or_sender(bus_target_or_sender),
        .bus_busy(bus_busy), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int i, input logic v, input logic [3:0] op,
                        input logic [47:0] d, input logic [5:0] t);
        req_valid[i]        = v;
        req_op[i*4 +: 4]    = op;
        req_data[i*48 +: 48] = d;
        req_target[i*6 +: 6] = t;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [64:0] oh(input int i);
        logic [64:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        int e;
        rst_n = 1'b0; req = '0; req_valid = '0;
        req_op = '0; req_data = '0; req_target = '0;
        tick; tick;
        chk("rst_grant", grant, 0);
        chk("rst_op", bus_op, 0);
        chk("rst_busy", bus_busy, 0);
        chk("rst_data", bus_data, 0);
        chk("rst_tos", bus_target_or_sender, 0);
        chk("rst_to", timeout_pulse, 0);
        rst_n = 1'b1;

        // single CIM 5, non-owner CIM 6 drives noise
        req[5] = 1'b1;
        beat(5, 1'b1, 4'd3, 48'h1234_5678_9abc, 6'd9);
        beat(6, 1'b1, 4'hf, 48'hffff, 6'd2);
        tick;
        chk("c5_grant", grant, oh(5));
        chk("c5_busy", bus_busy, 1);
        chk("c5_op_lat", bus_op, 0);
        tick;
        chk("c5_op", bus_op, 3);
        chk("c5_tos", bus_target_or_sender, 4);
        chk("c5_data", bus_data, 48'h1234_5678_9abc);
        beat(5, 1'b0, 4'd3, 48'h5555, 6'd9);
        tick;
        chk("idle_op", bus_op, 0);
        chk("idle_hold", bus_data, 48'h1234_5678_9abc);
        beat(5, 1'b1, 4'd3, 48'h8000_0000_0001, 6'd9);
        tick;
        chk("idle_op2", bus_op, 3);
        chk("idle_data2", bus_data, 48'h8000_0000_0001);
        req[5] = 1'b0;
        beat(5, 1'b1, 4'd7, 48'h7777, 6'd9);
        tick;
        chk("c5_turn_grant", grant, 0);
        chk("c5_turn_op", bus_op, 0);
        chk("c5_turn_data", bus_data, 48'h8000_0000_0001);
        chk("c5_turn_busy", bus_busy, 0);
        chk("c5_turn_to", timeout_pulse, 0);
        tick;
        chk("c5_idle", grant, 0);
        beat(5, 1'b0, 4'd0, 48'h0, 6'd0);
        beat(6, 1'b0, 4'd0, 48'h0, 6'd0);

        // reset mid-grant
        req[3] = 1'b1;
        beat(3, 1'b1, 4'd2, 48'h33, 6'd0);
        tick;
        chk("c3_grant", grant, oh(3));
        tick;
        chk("c3_op", bus_op, 2);
        rst_n = 1'b0;
        tick;
        chk("midrst_grant", grant, 0);
        chk("midrst_op", bus_op, 0);
        chk("midrst_busy", bus_busy, 0);
        rst_n = 1'b1;
        req[3] = 1'b0;
        beat(3, 1'b0, 4'd0, 48'h0, 6'd0);

        // contention: master, then CIM 2 (pointer back at 1), then CIM 7
        req[0] = 1'b1; req[2] = 1'b1; req[7] = 1'b1;
        beat(0, 1'b1, 4'd5, 48'habc, 6'd9);
        tick;
        chk("m_grant", grant, oh(0));
        tick;
        chk("m_op", bus_op, 5);
        chk("m_tos", bus_target_or_sender, 9);
        req[0] = 1'b0;
        beat(0, 1'b0, 4'd0, 48'h0, 6'd0);
        tick;
        chk("m_turn_grant", grant, 0);
        chk("m_turn_op", bus_op, 0);
        beat(2, 1'b1, 4'd2, 48'h2, 6'd0);
        tick;
        chk("c2_grant", grant, oh(2));
        tick;
        chk("c2_op", bus_op, 2);
        chk("c2_tos", bus_target_or_sender, 1);
        req[2] = 1'b0;
        beat(2, 1'b0, 4'd0, 48'h0, 6'd0);
        tick;
        chk("c2_turn", grant, 0);
        tick;
        chk("c7_grant", grant, oh(7));
        req[7] = 1'b0;
        tick; tick;

        // round-robin between CIM 2 and CIM 4
        req[2] = 1'b1; req[4] = 1'b1;
        beat(2, 1'b1, 4'd1, 48'h22, 6'd0);
        beat(4, 1'b1, 4'd8, 48'h44, 6'd0);
        for (int g = 0; g < 4; g++) begin
            e = (g % 2 == 0) ? 2 : 4;
            tick;
            chk("rr_grant", grant, oh(e));
            tick; tick;
            chk("rr_tos", bus_target_or_sender, e - 1);
            chk("rr_op", bus_op, (e == 2) ? 1 : 8);
            req[e] = 1'b0;
            tick;
            chk("rr_turn_op", bus_op, 0);
            chk("rr_turn_grant", grant, 0);
            if (g < 3) req[e] = 1'b1;
            else begin req[2] = 1'b0; req[4] = 1'b0; end
        end
        tick;
        beat(2, 1'b0, 4'd0, 48'h0, 6'd0);
        beat(4, 1'b0, 4'd0, 48'h0, 6'd0);

        // CIM 64 sender ID, then pointer wrap 64 -> 1
        req[64] = 1'b1;
        beat(64, 1'b1, 4'hc, 48'h64, 6'd0);
        tick;
        chk("c64_grant", grant, oh(64));
        tick;
        chk("c64_tos", bus_target_or_sender, 63);
        chk("c64_op", bus_op, 4'hc);
        req[64] = 1'b0;
        beat(64, 1'b0, 4'd0, 48'h0, 6'd0);
        tick;
        req[63] = 1'b1;
        tick;
        chk("c63_grant", grant, oh(63));
        req[63] = 1'b0;
        tick;
        req[1] = 1'b1; req[3] = 1'b1;
        beat(1, 1'b1, 4'd9, 48'h1111, 6'd0);
        tick;
        chk("wrap_grant", grant, oh(1));
        req[3] = 1'b0;

`ifdef CIM_BUS_ARB_TIMEOUT_EN
        req[6] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            tick;
            chk("to_beat_op", bus_op, 9);
            chk("to_beat_pulse", timeout_pulse, 0);
        end
        tick;
        chk("to_pulse", timeout_pulse, 1);
        chk("to_op", bus_op, 0);
        chk("to_grant", grant, 0);
        tick;
        chk("to_regrant", grant, oh(6));
        chk("to_pulse_clr", timeout_pulse, 0);
        req[1] = 1'b0; req[6] = 1'b0;
        tick; tick;
`else
        tick;
        chk("c1_op", bus_op, 9);
        req[1] = 1'b0;
        tick;
        chk("c1_turn_grant", grant, 0);
        chk("c1_turn_to", timeout_pulse, 0);
        tick;
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
